// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bundle: decoded ID fields, forwarding sources and EX-side outputs.
// The slave modport is the stage itself; master is whoever drives ID and the forwarding buses.
interface ex_operand_if #(
  parameter int N = 32,
  parameter int R = 5
);
  logic         id_valid;
  logic [N-1:0] id_rs1_data;
  logic [N-1:0] id_rs2_data;
  logic [N-1:0] id_imm;
  logic [R-1:0] id_rs1;
  logic [R-1:0] id_rs2;
  logic [R-1:0] id_rd;
  logic [1:0]   id_alu_op;
  logic [2:0]   id_funct3;
  logic         id_funct7b5;
  logic         id_alu_src;
  logic         id_reg_write;
  logic         id_mem_read;
  logic         stall;
  logic         flush;
  logic         mem_reg_write;
  logic [R-1:0] mem_rd;
  logic [N-1:0] mem_result;
  logic         wb_reg_write;
  logic [R-1:0] wb_rd;
  logic [N-1:0] wb_result;
  logic         ex_valid;
  logic [N-1:0] ex_alu_a;
  logic [N-1:0] ex_alu_b;
  logic [3:0]   ex_alu_sel;
  logic [N-1:0] ex_store_data;
  logic [R-1:0] ex_rd;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic         hazard_stall;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7b5, id_alu_src, id_reg_write, id_mem_read,
           stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7b5, id_alu_src, id_reg_write, id_mem_read,
           stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, hazard_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX register stage feeding the ALU: operand select, Sel decode, load-use detection.
// Define EX_FWD_EN to enable EX/MEM and MEM/WB forwarding onto the operand paths.
module ex_operand_stage #(
  parameter int N = 32,
  parameter int R = 5
) (
  input logic          clk,
  input logic          rst,
  ex_operand_if.slave  bus_io
);

  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_BAD = 4'b1111;

  function automatic logic [3:0] decode_sel(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7b5, input logic src);
    logic [3:0] sel;
    sel = SEL_BAD;
    case (op)
      2'b00: sel = SEL_ADD;
      2'b01: sel = SEL_SUB;
      2'b10: begin
        case (f3)
          3'b000:  sel = (f7b5 & ~src) ? SEL_SUB : SEL_ADD;
          3'b111:  sel = SEL_AND;
          3'b110:  sel = SEL_OR;
          default: sel = SEL_BAD;
        endcase
      end
      default: sel = SEL_BAD;
    endcase
    return sel;
  endfunction

  logic         valid_q, valid_d;
  logic         reg_write_q, reg_write_d;
  logic         mem_read_q, mem_read_d;
  logic         alu_src_q, alu_src_d;
  logic [R-1:0] rd_q, rd_d;
  logic [R-1:0] rs1_q, rs1_d;
  logic [R-1:0] rs2_q, rs2_d;
  logic [N-1:0] rs1_data_q, rs1_data_d;
  logic [N-1:0] rs2_data_q, rs2_data_d;
  logic [N-1:0] imm_q, imm_d;
  logic [3:0]   sel_q, sel_d;
  logic         hazard;
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  // A load in EX whose rd is needed by ID cannot be forwarded in time.
  assign hazard = valid_q & mem_read_q & (rd_q != '0) & bus_io.id_valid &
                  ((rd_q == bus_io.id_rs1) | ((rd_q == bus_io.id_rs2) & ~bus_io.id_alu_src));

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    alu_src_d   = alu_src_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    sel_d       = sel_q;
    if (bus_io.flush || (!bus_io.stall && hazard)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      alu_src_d   = 1'b0;
      rd_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      sel_d       = SEL_ADD;
    end else if (!bus_io.stall) begin
      valid_d     = bus_io.id_valid;
      reg_write_d = bus_io.id_reg_write & bus_io.id_valid;
      mem_read_d  = bus_io.id_mem_read & bus_io.id_valid;
      alu_src_d   = bus_io.id_alu_src;
      rd_d        = bus_io.id_rd;
      rs1_d       = bus_io.id_rs1;
      rs2_d       = bus_io.id_rs2;
      rs1_data_d  = bus_io.id_rs1_data;
      rs2_data_d  = bus_io.id_rs2_data;
      imm_d       = bus_io.id_imm;
      sel_d       = decode_sel(bus_io.id_alu_op, bus_io.id_funct3,
                               bus_io.id_funct7b5, bus_io.id_alu_src);
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_src_q   <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      sel_q       <= SEL_ADD;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      alu_src_q   <= alu_src_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      sel_q       <= sel_d;
    end
  end

`ifdef EX_FWD_EN
  // MEM is younger than WB, so it wins; x0 is hard-wired and never forwarded.
  always_comb begin
    fwd_a = rs1_data_q;
    if (bus_io.mem_reg_write && (bus_io.mem_rd != '0) && (bus_io.mem_rd == rs1_q))
      fwd_a = bus_io.mem_result;
    else if (bus_io.wb_reg_write && (bus_io.wb_rd != '0) && (bus_io.wb_rd == rs1_q))
      fwd_a = bus_io.wb_result;
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (bus_io.mem_reg_write && (bus_io.mem_rd != '0) && (bus_io.mem_rd == rs2_q))
      fwd_b = bus_io.mem_result;
    else if (bus_io.wb_reg_write && (bus_io.wb_rd != '0) && (bus_io.wb_rd == rs2_q))
      fwd_b = bus_io.wb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus_io.mem_reg_write, bus_io.mem_rd, bus_io.mem_result,
                        bus_io.wb_reg_write, bus_io.wb_rd, bus_io.wb_result, rs1_q, rs2_q};
  assign fwd_a = rs1_data_q;
  assign fwd_b = rs2_data_q;
`endif

  assign bus_io.ex_valid      = valid_q;
  assign bus_io.ex_alu_a      = fwd_a;
  assign bus_io.ex_store_data = fwd_b;
  assign bus_io.ex_alu_b      = alu_src_q ? imm_q : fwd_b;
  assign bus_io.ex_alu_sel    = valid_q ? sel_q : SEL_ADD;
  assign bus_io.ex_rd         = rd_q;
  assign bus_io.ex_reg_write  = reg_write_q & valid_q;
  assign bus_io.ex_mem_read   = mem_read_q & valid_q;
  assign bus_io.hazard_stall  = hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed table, hand-written corner sequences, random run vs model.
module tb_ex_operand_stage;
  localparam int N = 32;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_operand_if #(.N(N), .R(R)) bus ();
  ex_operand_stage #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic         v;
    logic         rw;
    logic         mr;
    logic         src;
    logic [R-1:0] rd;
    logic [R-1:0] rs1;
    logic [R-1:0] rs2;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] imm;
    logic [3:0]   sel;
  } ex_t;

  ex_t m;

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   f3;
    logic         f7;
    logic         src;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] imm;
    logic [3:0]   exp_sel;
    logic [N-1:0] exp_b;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7, input logic src);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd3) return 4'b1111;
    if (f3 == 3'd0) return (f7 && !src) ? 4'b0110 : 4'b0010;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    return 4'b1111;
  endfunction

  function automatic logic [N-1:0] ref_fwd(input logic [R-1:0] idx, input logic [N-1:0] rf);
`ifdef EX_FWD_EN
    if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == idx) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == idx) return bus.wb_result;
`endif
    return rf;
  endfunction

  function automatic logic ref_hazard();
    return m.v && m.mr && m.rd != 0 && bus.id_valid &&
           (m.rd == bus.id_rs1 || (m.rd == bus.id_rs2 && !bus.id_alu_src));
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] s;
    s = ref_fwd(m.rs2, m.d2);
    check("ex_valid", bus.ex_valid, m.v);
    check("ex_alu_a", bus.ex_alu_a, ref_fwd(m.rs1, m.d1));
    check("ex_store_data", bus.ex_store_data, s);
    check("ex_alu_b", bus.ex_alu_b, m.src ? m.imm : s);
    check("ex_alu_sel", bus.ex_alu_sel, m.v ? m.sel : 4'b0010);
    check("ex_rd", bus.ex_rd, m.rd);
    check("ex_reg_write", bus.ex_reg_write, m.v & m.rw);
    check("ex_mem_read", bus.ex_mem_read, m.v & m.mr);
  endtask

  task automatic tick();
    ex_t nxt;
    #1;
    check("hazard_stall", bus.hazard_stall, ref_hazard());
    nxt = m;
    if (rst || bus.flush || (!bus.stall && ref_hazard())) begin
      nxt = '0;
      nxt.sel = 4'b0010;
    end else if (!bus.stall) begin
      nxt.v   = bus.id_valid;
      nxt.rw  = bus.id_reg_write & bus.id_valid;
      nxt.mr  = bus.id_mem_read & bus.id_valid;
      nxt.src = bus.id_alu_src;
      nxt.rd  = bus.id_rd;
      nxt.rs1 = bus.id_rs1;
      nxt.rs2 = bus.id_rs2;
      nxt.d1  = bus.id_rs1_data;
      nxt.d2  = bus.id_rs2_data;
      nxt.imm = bus.id_imm;
      nxt.sel = ref_sel(bus.id_alu_op, bus.id_funct3, bus.id_funct7b5, bus.id_alu_src);
    end
    @(posedge clk);
    #1;
    m = nxt;
    check_outputs();
  endtask

  task automatic set_id(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic src, input logic [R-1:0] rs1, input logic [R-1:0] rs2,
                        input logic [R-1:0] rd, input logic [N-1:0] d1, input logic [N-1:0] d2,
                        input logic [N-1:0] imm, input logic mr);
    bus.id_valid     = 1'b1;
    bus.id_alu_op    = op;
    bus.id_funct3    = f3;
    bus.id_funct7b5  = f7;
    bus.id_alu_src   = src;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_rs1_data  = d1;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = mr;
  endtask

  initial begin
    tbl[0]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd9, 32'd4, 32'h100, 4'b0110, 32'd4};
    tbl[1]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd9, 32'd4, 32'h100, 4'b0010, 32'h100};
    tbl[2]  = '{2'b10, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0,   4'b0010, 32'd2};
    tbl[3]  = '{2'b10, 3'b111, 1'b0, 1'b0, 32'd3, 32'd5, 32'h0,   4'b0000, 32'd5};
    tbl[4]  = '{2'b10, 3'b110, 1'b0, 1'b0, 32'd3, 32'd6, 32'h0,   4'b0001, 32'd6};
    tbl[5]  = '{2'b10, 3'b100, 1'b0, 1'b0, 32'd3, 32'd7, 32'h0,   4'b1111, 32'd7};
    tbl[6]  = '{2'b00, 3'b111, 1'b1, 1'b0, 32'd3, 32'd8, 32'h0,   4'b0010, 32'd8};
    tbl[7]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd3, 32'd9, 32'h0,   4'b0110, 32'd9};
    tbl[8]  = '{2'b11, 3'b000, 1'b0, 1'b0, 32'd3, 32'hA, 32'h0,   4'b1111, 32'hA};
    tbl[9]  = '{2'b00, 3'b000, 1'b0, 1'b1, 32'd3, 32'hB, 32'hFFFFFFFC, 4'b0010, 32'hFFFFFFFC};
    tbl[10] = '{2'b10, 3'b001, 1'b0, 1'b0, 32'd3, 32'hC, 32'h0,   4'b1111, 32'hC};

    set_id(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 1'b0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.mem_reg_write = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
    bus.wb_reg_write = 1'b0;  bus.wb_rd = '0;  bus.wb_result = '0;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    #1;
    m = '0;
    m.sel = 4'b0010;
    check_outputs();
    check("reset_sel", bus.ex_alu_sel, 32'h2);
    rst = 1'b0;

    // Directed decode/operand table
    for (int i = 0; i < 11; i++) begin
      set_id(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].src, 5'd1, 5'd2, 5'd3,
             tbl[i].d1, tbl[i].d2, tbl[i].imm, 1'b0);
      tick();
      check($sformatf("tbl%0d_sel", i), bus.ex_alu_sel, tbl[i].exp_sel);
      check($sformatf("tbl%0d_b", i), bus.ex_alu_b, tbl[i].exp_b);
      check($sformatf("tbl%0d_a", i), bus.ex_alu_a, tbl[i].d1);
    end

    // Forwarding priority on rs1 = x3
    set_id(2'b00, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h55, 32'h66, 32'h0, 1'b0);
    tick();
    bus.stall = 1'b1;
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd3; bus.mem_result = 32'h11;
    bus.wb_reg_write = 1'b1;  bus.wb_rd = 5'd3;  bus.wb_result = 32'h22;
    #1;
`ifdef EX_FWD_EN
    check("fwd_mem_wins", bus.ex_alu_a, 32'h11);
`else
    check("fwd_off_a", bus.ex_alu_a, 32'h55);
`endif
    bus.mem_reg_write = 1'b0;
    #1;
`ifdef EX_FWD_EN
    check("fwd_wb", bus.ex_alu_a, 32'h22);
`else
    check("fwd_off_a2", bus.ex_alu_a, 32'h55);
`endif
    tick();
    bus.stall = 1'b0;
    bus.wb_reg_write = 1'b0;

    // x0 is never forwarded
    set_id(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 5'd4, 5'd5, 32'h0, 32'h1, 32'h0, 1'b0);
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.mem_result = 32'd5;
    tick();
    check("x0_no_fwd", bus.ex_alu_a, 32'h0);
    bus.mem_reg_write = 1'b0;

    // Load-use hazard on rs2 (R-type)
    set_id(2'b00, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h10, 1'b1);
    tick();
    set_id(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd7, 5'd8, 32'h1, 32'h2, 32'h0, 1'b0);
    #1;
    check("loaduse_hz", bus.hazard_stall, 1'b1);
    tick();
    check("loaduse_bubble_v", bus.ex_valid, 1'b0);
    check("loaduse_bubble_rw", bus.ex_reg_write, 1'b0);
    tick();
    // I-type reading rd only through the unused rs2 slot: no hazard
    set_id(2'b00, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h10, 1'b1);
    tick();
    set_id(2'b00, 3'b000, 1'b0, 1'b1, 5'd2, 5'd7, 5'd8, 32'h1, 32'h2, 32'h3, 1'b0);
    #1;
    check("imm_no_hz", bus.hazard_stall, 1'b0);
    tick();
    check("imm_no_hz_v", bus.ex_valid, 1'b1);

    // Stall freezes EX for three cycles
    set_id(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'h0, 1'b0);
    tick();
    set_id(2'b10, 3'b111, 1'b0, 1'b1, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h3, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_v", bus.ex_valid, 1'b1);
      check("stall_a", bus.ex_alu_a, 32'hAA);
      check("stall_b", bus.ex_alu_b, 32'hBB);
      check("stall_sel", bus.ex_alu_sel, 4'b0110);
      check("stall_rd", bus.ex_rd, 5'd9);
    end
    bus.flush = 1'b1;
    tick();
    check("stall_flush_v", bus.ex_valid, 1'b0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_v", bus.ex_valid, 1'b0);
    check("midrst_sel", bus.ex_alu_sel, 4'b0010);
    rst = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] f3pick;
      f3pick = 3'($urandom_range(0, 3));
      bus.id_valid      = ($urandom_range(0, 7) != 0);
      bus.id_alu_op     = 2'($urandom);
      bus.id_funct3     = (f3pick == 0) ? 3'd0 : (f3pick == 1) ? 3'd7 :
                          (f3pick == 2) ? 3'd6 : 3'($urandom);
      bus.id_funct7b5   = 1'($urandom);
      bus.id_alu_src    = 1'($urandom);
      bus.id_rs1        = 5'($urandom_range(0, 7));
      bus.id_rs2        = 5'($urandom_range(0, 7));
      bus.id_rd         = 5'($urandom_range(0, 7));
      bus.id_rs1_data   = $urandom;
      bus.id_rs2_data   = $urandom;
      bus.id_imm        = $urandom;
      bus.id_reg_write  = 1'($urandom);
      bus.id_mem_read   = ($urandom_range(0, 2) == 0);
      bus.stall         = ($urandom_range(0, 7) == 0);
      bus.flush         = ($urandom_range(0, 9) == 0);
      bus.mem_reg_write = 1'($urandom);
      bus.mem_rd        = 5'($urandom_range(0, 7));
      bus.mem_result    = $urandom;
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_rd         = 5'($urandom_range(0, 7));
      bus.wb_result     = $urandom;
      rst               = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the N-bit ALU.
- Registers decoded operands and control from ID, and resolves EX/MEM and MEM/WB forwarding for rs1/rs2.
- Selects the immediate or register B operand, decodes alu_op/funct into the ALU's 4-bit Sel, and detects load-use hazards.
- Outputs feed ALU inputs A, B and Sel combinationally.

Parameters:
- N, 32, datapath width.
- R, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_data, id_rs2_data  in  N  register-file read data.
- id_imm  in  N  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  R  register indices.
- id_alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved.
- id_funct3  in  3  instruction funct3.
- id_funct7b5  in  1  instruction bit 30.
- id_alu_src  in  1  1 = B is the immediate (I-type); 0 = B is rs2 (R-type).
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- stall  in  1  external hold (e.g. memory wait).
- flush  in  1  kill the instruction entering EX (branch taken).
- mem_reg_write  in  1  EX/MEM writes rd.
- mem_rd  in  R  EX/MEM destination.
- mem_result  in  N  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB writes rd.
- wb_rd  in  R  MEM/WB destination.
- wb_result  in  N  MEM/WB writeback value.
- ex_valid  out  1  EX holds a valid instruction.
- ex_alu_a  out  N  ALU operand A.
- ex_alu_b  out  N  ALU operand B.
- ex_alu_sel  out  4  ALU Sel.
- ex_store_data  out  N  forwarded rs2 value, for stores.
- ex_rd  out  R  registered destination.
- ex_reg_write  out  1  registered write enable, gated by ex_valid.
- ex_mem_read  out  1  registered load flag, gated by ex_valid.
- hazard_stall  out  1  combinational request for ID/IF to hold.

Behaviour:
- All state updates on posedge clk. Update priority: rst > flush > stall > hazard bubble > load.
- rst: all registered fields cleared. ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd=0, registered data=0, registered sel=4'b0010.
- flush (with or without stall): insert bubble. ex_valid, ex_reg_write, ex_mem_read go to 0; data fields are don't-care but cleared to 0.
- stall (no flush): all registers hold their value. hazard_stall is still computed.
- hazard_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2 & ~id_alu_src)).
- When hazard_stall=1 and no stall/flush: insert bubble (same as flush); ID is expected to hold.
- Otherwise: load all id_* fields. ex_valid <= id_valid. reg_write and mem_read are ANDed with id_valid.
- Sel decode, registered at load:
  - alu_op 00 -> 4'b0010.
  - alu_op 01 -> 4'b0110.
  - alu_op 10, funct3 000 -> 4'b0110 if funct7b5 & ~alu_src, else 4'b0010.
  - alu_op 10, funct3 111 -> 4'b0000.
  - alu_op 10, funct3 110 -> 4'b0001.
  - Any other funct3, or alu_op 11 -> 4'b1111 (unsupported; ALU drives 0).
  - ex_alu_sel is forced to 4'b0010 while ex_valid=0.
- Forwarding, combinational from registered rs1/rs2. For each source index s:
  - If mem_reg_write & mem_rd != 0 & mem_rd == s: use mem_result.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == s: use wb_result.
  - Else: use the registered register-file data.
  - MEM beats WB when both match. x0 is never forwarded.
- ex_alu_a = forwarded rs1.
- ex_store_data = forwarded rs2.
- ex_alu_b = registered imm if the registered alu_src=1, else forwarded rs2.
- Latency: one cycle from ID to EX registers; zero cycles from forwarding inputs to outputs.

Optional Feature:
- EX_FWD_EN.
- Defined: forwarding paths as described.
- Undefined: no forwarding muxes. ex_alu_a, ex_alu_b and ex_store_data come from registered data only; mem_*/wb_* inputs are unused.
- hazard_stall is unchanged in both builds.

Test Plan:
- Load-stage: alu_op=10, funct3=000, funct7b5=1, alu_src=0, rs1_data=9, rs2_data=4 -> next cycle ex_alu_sel=0110, ex_alu_a=9, ex_alu_b=4.
- Forward priority: registered rs1=3; mem_rd=3, mem_result=0x11; wb_rd=3, wb_result=0x22, both writing -> ex_alu_a=0x11. Drop mem_reg_write -> ex_alu_a=0x22.
- x0: rs1=0, mem_rd=0, mem_reg_write=1, mem_result=5 -> ex_alu_a equals the registered rs1_data (0).
- Load-use: EX holds a load to rd=7, ID rs2=7, alu_src=0 -> hazard_stall=1; next cycle ex_valid=0, ex_reg_write=0. Same case with alu_src=1 and rs1≠7 -> hazard_stall=0.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen. stall=1 and flush=1 -> ex_valid=0 next cycle. rst=1 mid-stream -> ex_valid=0, ex_alu_sel=0010 next edge.
- Unsupported: alu_op=10, funct3=100 -> ex_alu_sel=1111. Immediate path: alu_src=1, imm=0xFFFFFFFC -> ex_alu_b=0xFFFFFFFC.
